// File: rtl/buffer_feeder.sv
`default_nettype none
// ============================================================================
// Module   : buffer_feeder
// Brief    : Latches a multi-row snapshot and streams it one row per
//            ready/valid transfer, with optional lane compaction.
// Revision : 1.0
// ============================================================================
module buffer_feeder #(
    parameter int BIT_WIDTH   = 8,
    parameter int BUFFER_SZ   = 32,
    parameter int INDEX_WIDTH = 6,
    parameter int ARRAY_DIM   = 32,
    parameter int DIM_WIDTH   = 5
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   wen,
    input  logic [BUFFER_SZ*ARRAY_DIM*BIT_WIDTH-1:0] in_buffer,
    input  logic [INDEX_WIDTH-1:0]                 in_buffer_index,
    input  logic [DIM_WIDTH-2:0]                   compact_en,
    output logic                                   pushed,
    output logic                                   row_valid,
    input  logic                                   row_ready,
    output logic [ARRAY_DIM*BIT_WIDTH-1:0]         row_data,
    output logic [INDEX_WIDTH-1:0]                 row_index,
    output logic                                   row_last,
    output logic                                   busy
);

    localparam int C_ROW_W  = ARRAY_DIM * BIT_WIDTH;
    localparam int C_SEL_W  = (BUFFER_SZ > 1) ? $clog2(BUFFER_SZ) : 1;
    localparam int C_MAX_CE = ARRAY_DIM / 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEND    = 2'd2
    } state_t;

    state_t                   r_state;
    logic [C_ROW_W-1:0]       r_rows [BUFFER_SZ];
    logic [INDEX_WIDTH-1:0]   r_count;
    logic [INDEX_WIDTH-1:0]   r_ptr;
    logic [ARRAY_DIM-1:0]     r_lane_mask;

    int                       w_ce;
    int                       w_lanes;
    logic [ARRAY_DIM-1:0]     w_lane_mask;
    logic [INDEX_WIDTH-1:0]   w_next_ptr;
    logic [C_SEL_W-1:0]       w_sel_idx;
    logic [C_ROW_W-1:0]       w_sel_row;
    logic [C_ROW_W-1:0]       w_masked_row;

    // Compaction code 0 behaves like 1; codes above ARRAY_DIM/4 saturate.
    always_comb begin
        w_ce = int'(compact_en);
        if (w_ce < 1)
            w_ce = 1;
        if (w_ce > C_MAX_CE)
            w_ce = C_MAX_CE;
        w_lanes = ARRAY_DIM + 4 - 4 * w_ce;
        for (int l = 0; l < ARRAY_DIM; l++)
            w_lane_mask[l] = (l < w_lanes);
    end

    assign w_next_ptr = r_ptr + INDEX_WIDTH'(1);
    assign w_sel_idx  = (r_state == CAPTURE) ? '0 : C_SEL_W'(w_next_ptr);
    assign w_sel_row  = r_rows[w_sel_idx];

    always_comb begin
        w_masked_row = '0;
        for (int l = 0; l < ARRAY_DIM; l++)
            if (r_lane_mask[l])
                w_masked_row[l*BIT_WIDTH +: BIT_WIDTH] = w_sel_row[l*BIT_WIDTH +: BIT_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_ptr       <= '0;
            r_lane_mask <= '0;
            pushed      <= 1'b0;
            row_valid   <= 1'b0;
            row_data    <= '0;
            row_index   <= '0;
            row_last    <= 1'b0;
            busy        <= 1'b0;
            for (int r = 0; r < BUFFER_SZ; r++)
                r_rows[r] <= '0;
        end else begin
            pushed <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (wen) begin
                        for (int r = 0; r < BUFFER_SZ; r++)
                            r_rows[r] <= in_buffer[r*C_ROW_W +: C_ROW_W];
                        r_count     <= (int'(in_buffer_index) > BUFFER_SZ) ?
                                       INDEX_WIDTH'(BUFFER_SZ) : in_buffer_index;
                        r_lane_mask <= w_lane_mask;
                        pushed      <= 1'b1;
                        busy        <= 1'b1;
                        r_state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    r_ptr <= '0;
                    if (r_count != '0) begin
                        r_state   <= SEND;
                        row_valid <= 1'b1;
                        row_index <= '0;
                        row_last  <= (r_count == INDEX_WIDTH'(1));
                        row_data  <= w_masked_row;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                SEND: begin
                    // Outputs only move on a transfer, so a stall holds them.
                    if (row_ready) begin
                        if (row_last) begin
                            r_state   <= IDLE;
                            busy      <= 1'b0;
                            row_valid <= 1'b0;
                            row_last  <= 1'b0;
                            row_index <= '0;
                            row_data  <= '0;
                            r_ptr     <= '0;
                        end else begin
                            r_ptr     <= w_next_ptr;
                            row_index <= w_next_ptr;
                            row_last  <= (w_next_ptr == r_count - INDEX_WIDTH'(1));
                            row_data  <= w_masked_row;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_buffer_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_buffer_feeder
// Brief    : Directed self-checking bench for buffer_feeder (default params).
// Revision : 1.0
// ============================================================================
module tb_buffer_feeder;

    localparam int C_BW = 8;
    localparam int C_BS = 32;
    localparam int C_IW = 6;
    localparam int C_AD = 32;
    localparam int C_DW = 5;

    logic                        clk;
    logic                        resetn;
    logic                        wen;
    logic [C_BS*C_AD*C_BW-1:0]   in_buffer;
    logic [C_IW-1:0]             in_buffer_index;
    logic [C_DW-2:0]             compact_en;
    logic                        pushed;
    logic                        row_valid;
    logic                        row_ready;
    logic [C_AD*C_BW-1:0]        row_data;
    logic [C_IW-1:0]             row_index;
    logic                        row_last;
    logic                        busy;

    int errors = 0;
    int checks = 0;

    buffer_feeder #(
        .BIT_WIDTH   (C_BW),
        .BUFFER_SZ   (C_BS),
        .INDEX_WIDTH (C_IW),
        .ARRAY_DIM   (C_AD),
        .DIM_WIDTH   (C_DW)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .wen             (wen),
        .in_buffer       (in_buffer),
        .in_buffer_index (in_buffer_index),
        .compact_en      (compact_en),
        .pushed          (pushed),
        .row_valid       (row_valid),
        .row_ready       (row_ready),
        .row_data        (row_data),
        .row_index       (row_index),
        .row_last        (row_last),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] elem(int seed, int r, int l);
        return 8'(seed * 7 + r * 13 + l * 3 + 1);
    endfunction

    function automatic logic [C_BS*C_AD*C_BW-1:0] build_buf(int seed);
        logic [C_BS*C_AD*C_BW-1:0] b;
        b = '0;
        for (int r = 0; r < C_BS; r++)
            for (int l = 0; l < C_AD; l++)
                b[C_BW*(C_AD*r+l) +: C_BW] = elem(seed, r, l);
        return b;
    endfunction

    function automatic logic [C_AD*C_BW-1:0] exp_row(int seed, int r, int lanes);
        logic [C_AD*C_BW-1:0] d;
        d = '0;
        for (int l = 0; l < lanes; l++)
            d[C_BW*l +: C_BW] = elem(seed, r, l);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_row(input string tag, input int seed, input int r,
                           input int lanes, input logic last);
        chk({tag, "_valid"}, 256'(row_valid), 256'(1));
        chk({tag, "_index"}, 256'(row_index), 256'(r));
        chk({tag, "_data"},  256'(row_data),  256'(exp_row(seed, r, lanes)));
        chk({tag, "_last"},  256'(row_last),  256'(last));
    endtask

    task automatic capture(input int seed, input int idx, input int ce);
        in_buffer       = build_buf(seed);
        in_buffer_index = C_IW'(idx);
        compact_en      = (C_DW-1)'(ce);
        wen             = 1'b1;
        step();
        wen             = 1'b0;
    endtask

    int rows;

    initial begin
        resetn = 1'b0; wen = 1'b0; row_ready = 1'b1;
        in_buffer = '0; in_buffer_index = '0; compact_en = '0;
        step(); step();
        chk("rst_pushed", 256'(pushed), 256'(0));
        chk("rst_valid",  256'(row_valid), 256'(0));
        chk("rst_busy",   256'(busy), 256'(0));
        chk("rst_data",   256'(row_data), 256'(0));
        chk("rst_index",  256'(row_index), 256'(0));
        resetn = 1'b1;
        step();
        chk("idle_pushed", 256'(pushed), 256'(0));

        // Basic 3-row stream; in_buffer changed right after capture must not leak.
        capture(1, 3, 1);
        in_buffer = build_buf(9);
        chk("t1_pushed", 256'(pushed), 256'(1));
        chk("t1_busy",   256'(busy), 256'(1));
        chk("t1_cvalid", 256'(row_valid), 256'(0));
        step();
        chk("t1_pushed_once", 256'(pushed), 256'(0));
        chk_row("t1_r0", 1, 0, 32, 1'b0);
        step(); chk_row("t1_r1", 1, 1, 32, 1'b0);
        step(); chk_row("t1_r2", 1, 2, 32, 1'b1);
        step();
        chk("t1_done_valid", 256'(row_valid), 256'(0));
        chk("t1_done_busy",  256'(busy), 256'(0));
        chk("t1_done_last",  256'(row_last), 256'(0));

        // Lane compaction: code 3 -> 24 lanes, code 15 saturates -> 4 lanes, code 0 -> 32.
        capture(2, 2, 3);
        step(); chk_row("ce3_r0", 2, 0, 24, 1'b0);
        step(); chk_row("ce3_r1", 2, 1, 24, 1'b1);
        step();
        capture(3, 1, 15);
        step(); chk_row("ce15_r0", 3, 0, 4, 1'b1);
        step();
        capture(4, 1, 0);
        step(); chk_row("ce0_r0", 4, 0, 32, 1'b1);
        step();

        // Backpressure on row 1 for five cycles.
        capture(5, 4, 1);
        step(); chk_row("bp_r0", 5, 0, 32, 1'b0);
        step(); chk_row("bp_r1", 5, 1, 32, 1'b0);
        row_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_row($sformatf("bp_hold%0d", i), 5, 1, 32, 1'b0);
        end
        row_ready = 1'b1;
        step(); chk_row("bp_r2", 5, 2, 32, 1'b0);
        step(); chk_row("bp_r3", 5, 3, 32, 1'b1);
        step();
        chk("bp_done", 256'(busy), 256'(0));

        // Empty snapshot: one pulse, no rows.
        capture(6, 0, 1);
        chk("z_pushed", 256'(pushed), 256'(1));
        step();
        chk("z_busy",   256'(busy), 256'(0));
        chk("z_valid",  256'(row_valid), 256'(0));
        chk("z_pushed2", 256'(pushed), 256'(0));
        step();
        chk("z_valid2", 256'(row_valid), 256'(0));

        // Oversized row count clamps to 32 rows.
        capture(7, 40, 1);
        step();
        rows = 0;
        for (int i = 0; i < 40 && row_valid; i++) begin
            chk($sformatf("big_idx%0d", i), 256'(row_index), 256'(i));
            chk($sformatf("big_last%0d", i), 256'(row_last), 256'(i == 31));
            chk($sformatf("big_data%0d", i), 256'(row_data), 256'(exp_row(7, i, 32)));
            rows++;
            step();
        end
        chk("big_rows", 256'(rows), 256'(32));
        chk("big_idle", 256'(busy), 256'(0));

        // wen held high: no second pulse until back in IDLE.
        in_buffer = build_buf(8); in_buffer_index = 2; compact_en = 1; wen = 1'b1;
        step(); chk("wh_p0", 256'(pushed), 256'(1));
        step(); chk("wh_p1", 256'(pushed), 256'(0)); chk_row("wh_r0", 8, 0, 32, 1'b0);
        step(); chk("wh_p2", 256'(pushed), 256'(0)); chk_row("wh_r1", 8, 1, 32, 1'b1);
        step(); chk("wh_p3", 256'(pushed), 256'(0)); chk("wh_idle", 256'(busy), 256'(0));
        step(); chk("wh_p4", 256'(pushed), 256'(1));
        wen = 1'b0;
        step(); chk("wh_p5", 256'(pushed), 256'(0)); chk_row("wh2_r0", 8, 0, 32, 1'b0);
        step(); chk_row("wh2_r1", 8, 1, 32, 1'b1);
        step();

        // Reset during row 5 of 10, then a fresh snapshot starts at row 0.
        capture(10, 10, 1);
        for (int i = 0; i < 6; i++) step();
        chk_row("mr_r5", 10, 5, 32, 1'b0);
        resetn = 1'b0;
        step();
        chk("mr_pushed", 256'(pushed), 256'(0));
        chk("mr_valid",  256'(row_valid), 256'(0));
        chk("mr_last",   256'(row_last), 256'(0));
        chk("mr_busy",   256'(busy), 256'(0));
        chk("mr_index",  256'(row_index), 256'(0));
        chk("mr_data",   256'(row_data), 256'(0));
        resetn = 1'b1;
        step();
        chk("mr_nopush", 256'(pushed), 256'(0));
        chk("mr_stayidle", 256'(busy), 256'(0));
        capture(11, 10, 1);
        chk("mr_newpush", 256'(pushed), 256'(1));
        step(); chk_row("mr_new_r0", 11, 0, 32, 1'b0);
        step(); chk_row("mr_new_r1", 11, 1, 32, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
